// File: rtl/box_compositor.sv
// Double-buffered multi-rectangle renderer with a two-stage hit/priority pipeline.
// Optional feature: define BOX_COMPOSITOR_COLLISION_EN to add the per-frame collision_mask output.
module box_compositor #(
  parameter int unsigned          NUM_BOXES = 8,
  parameter int unsigned          COORD_W   = 10,
  parameter int unsigned          COLOR_W   = 12,
  parameter logic [COLOR_W-1:0]   BG_COLOR  = '0
) (
  input  logic                         pixel_clk,
  input  logic                         reset,
  input  logic [COORD_W-1:0]           X_pix,
  input  logic [COORD_W-1:0]           Y_pix,
  input  logic                         frame_start,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [$clog2(NUM_BOXES)-1:0] cfg_index,
  input  logic [COORD_W-1:0]           cfg_x,
  input  logic [COORD_W-1:0]           cfg_y,
  input  logic [COORD_W-1:0]           cfg_w,
  input  logic [COORD_W-1:0]           cfg_h,
  input  logic [COLOR_W-1:0]           cfg_color,
  input  logic                         cfg_en,
  output logic [COLOR_W-1:0]           pixel_color,
  output logic                         hit_any,
  output logic [$clog2(NUM_BOXES)-1:0] hit_index
`ifdef BOX_COMPOSITOR_COLLISION_EN
  ,
  output logic [NUM_BOXES-1:0]         collision_mask
`endif
);

  localparam int unsigned IdxW = $clog2(NUM_BOXES);

  typedef struct packed {
    logic               en;
    logic [COLOR_W-1:0] color;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
  } box_t;

  box_t shadow_q [NUM_BOXES];
  box_t shadow_d [NUM_BOXES];
  box_t active_q [NUM_BOXES];

  logic [NUM_BOXES-1:0] hit_d, hit_q;
  logic                 win_any;
  logic [IdxW-1:0]      win_idx;
  logic [COLOR_W-1:0]   color_d, color_q;
  logic                 hit_any_q;
  logic [IdxW-1:0]      hit_index_q;

  assign cfg_ready = ~frame_start;

  always_comb begin
    shadow_d = shadow_q;
    if (cfg_valid && cfg_ready && (32'(cfg_index) < NUM_BOXES)) begin
      shadow_d[cfg_index] = '{en: cfg_en, color: cfg_color, x: cfg_x, y: cfg_y, w: cfg_w, h: cfg_h};
    end
  end

  // Right/bottom bounds use one extra bit so boxes running off the raster clip instead of wrapping.
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < int'(NUM_BOXES); i++) begin
      hit_d[i] = active_q[i].en
          && (X_pix >= active_q[i].x)
          && ({1'b0, X_pix} < ({1'b0, active_q[i].x} + {1'b0, active_q[i].w}))
          && (Y_pix >= active_q[i].y)
          && ({1'b0, Y_pix} < ({1'b0, active_q[i].y} + {1'b0, active_q[i].h}));
    end
  end

  // Scan from the top down so the lowest hitting index is the last one assigned.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int i = int'(NUM_BOXES) - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        win_any = 1'b1;
        win_idx = IdxW'(i);
      end
    end
    color_d = win_any ? active_q[win_idx].color : BG_COLOR;
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      shadow_q    <= '{default: '0};
      active_q    <= '{default: '0};
      hit_q       <= '0;
      color_q     <= BG_COLOR;
      hit_any_q   <= 1'b0;
      hit_index_q <= '0;
    end else begin
      shadow_q    <= shadow_d;
      if (frame_start) begin
        active_q <= shadow_q;
      end
      hit_q       <= hit_d;
      color_q     <= color_d;
      hit_any_q   <= win_any;
      hit_index_q <= win_idx;
    end
  end

  assign pixel_color = color_q;
  assign hit_any     = hit_any_q;
  assign hit_index   = hit_index_q;

`ifdef BOX_COMPOSITOR_COLLISION_EN
  logic [NUM_BOXES-1:0] coll_set;
  logic [NUM_BOXES-1:0] sticky_d, sticky_q;
  logic [NUM_BOXES-1:0] mask_d, mask_q;

  always_comb begin
    coll_set    = hit_q & {NUM_BOXES{hit_q[0]}};
    coll_set[0] = 1'b0;
    sticky_d    = frame_start ? '0 : (sticky_q | coll_set);
    mask_d      = frame_start ? (sticky_q | coll_set) : mask_q;
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      sticky_q <= '0;
      mask_q   <= '0;
    end else begin
      sticky_q <= sticky_d;
      mask_q   <= mask_d;
    end
  end

  assign collision_mask = mask_q;
`endif

endmodule
